// File: rtl/cmip_sync_pkt_fifo_if.sv
// Handshake and status bundle for cmip_sync_pkt_fifo.
// slave = FIFO side, master = producer/consumer side.
interface cmip_sync_pkt_fifo_if #(
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned ADDR_WDTH = 4
);
    logic [ADDR_WDTH:0]   i_aful_th;
    logic [ADDR_WDTH:0]   i_amty_th;
    logic                 i_wr;
    logic [DATA_WDTH-1:0] i_din;
    logic                 i_wr_last;
    logic                 i_wr_drop;
    logic                 i_rd;
    logic [DATA_WDTH-1:0] o_dout;
    logic                 o_dout_last;
    logic                 o_empty;
    logic                 o_full;
    logic                 o_aful;
    logic                 o_amty;
    logic                 o_ovfl_int;
    logic                 o_unfl_int;
    logic [ADDR_WDTH:0]   o_used_cnt;
    logic [ADDR_WDTH:0]   o_pkt_cnt;

    modport master (
        output i_aful_th, i_amty_th, i_wr, i_din, i_wr_last, i_wr_drop, i_rd,
        input  o_dout, o_dout_last, o_empty, o_full, o_aful, o_amty, o_ovfl_int, o_unfl_int,
               o_used_cnt, o_pkt_cnt
    );

    modport slave (
        input  i_aful_th, i_amty_th, i_wr, i_din, i_wr_last, i_wr_drop, i_rd,
        output o_dout, o_dout_last, o_empty, o_full, o_aful, o_amty, o_ovfl_int, o_unfl_int,
               o_used_cnt, o_pkt_cnt
    );
endinterface

// File: rtl/cmip_sync_pkt_fifo.sv
// Single-clock store-and-forward packet FIFO with FWFT output register and writer-side drop.
// Optional CMIP_PKT_FIFO_AUTO_DROP_EN: overflow discards the rest of the open packet.
module cmip_sync_pkt_fifo #(
    parameter int unsigned DPTH      = 16,
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned ADDR_WDTH = $clog2(DPTH)
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    cmip_sync_pkt_fifo_if.slave io_bus
);
    localparam int unsigned PW = ADDR_WDTH + 1;
    localparam logic [PW:0] DPTH_X = (PW + 1)'(DPTH);

    typedef enum logic [1:0] {StIdle, StInPkt, StDiscard} state_e;

    logic [DATA_WDTH:0]   r_mem [DPTH];
    logic [PW-1:0]        r_w_ptr, r_c_ptr, r_r_ptr, r_pkt_cnt;
    logic [DATA_WDTH-1:0] r_dout;
    logic                 r_dout_last, r_ovld;
    logic                 r_aful, r_amty, r_ovfl, r_unfl;
    state_e               r_state, w_state_nxt;

    logic [PW-1:0] w_fill, w_used;
    logic          w_full, w_discard, w_wr_ok, w_ovfl_evt, w_commit, w_pop, w_load, w_auto_drop;

    // Occupancy of the RAM only; the output register is accounted separately.
    assign w_fill     = r_w_ptr - r_r_ptr;
    assign w_full     = (w_fill == PW'(DPTH));
    assign w_used     = w_fill + PW'(r_ovld);
`ifdef CMIP_PKT_FIFO_AUTO_DROP_EN
    assign w_discard  = (r_state == StDiscard);
`else
    assign w_discard  = 1'b0;
`endif
    assign w_wr_ok    = io_bus.i_wr & ~w_full & ~io_bus.i_wr_drop & ~w_discard;
    assign w_ovfl_evt = io_bus.i_wr & w_full & ~io_bus.i_wr_drop & ~w_discard;
    assign w_commit   = w_wr_ok & io_bus.i_wr_last;
    assign w_pop      = io_bus.i_rd & r_ovld;
    assign w_load     = (r_c_ptr != r_r_ptr) & (~r_ovld | w_pop);
`ifdef CMIP_PKT_FIFO_AUTO_DROP_EN
    assign w_auto_drop = w_ovfl_evt;
`else
    assign w_auto_drop = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_auto_drop) w_state_nxt = io_bus.i_wr_last ? StIdle : StDiscard;
                else if (w_wr_ok && !io_bus.i_wr_last) w_state_nxt = StInPkt;
            end
            StInPkt: begin
                if (w_auto_drop) w_state_nxt = io_bus.i_wr_last ? StIdle : StDiscard;
                else if (w_commit || io_bus.i_wr_drop) w_state_nxt = StIdle;
            end
            StDiscard: begin
                if ((io_bus.i_wr && io_bus.i_wr_last) || io_bus.i_wr_drop) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_w_ptr[ADDR_WDTH-1:0]] <= {io_bus.i_wr_last, io_bus.i_din};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_w_ptr     <= '0;
            r_c_ptr     <= '0;
            r_r_ptr     <= '0;
            r_pkt_cnt   <= '0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
            r_ovld      <= 1'b0;
            r_aful      <= 1'b0;
            r_amty      <= 1'b1;
            r_ovfl      <= 1'b0;
            r_unfl      <= 1'b0;
        end else begin
            // Drop rewinds to the last committed boundary; a coincident beat is lost.
            if (io_bus.i_wr_drop || w_auto_drop) r_w_ptr <= r_c_ptr;
            else if (w_wr_ok)                    r_w_ptr <= r_w_ptr + PW'(1);
            if (w_commit) r_c_ptr <= r_w_ptr + PW'(1);
            if (w_load) begin
                {r_dout_last, r_dout} <= r_mem[r_r_ptr[ADDR_WDTH-1:0]];
                r_ovld                <= 1'b1;
                r_r_ptr               <= r_r_ptr + PW'(1);
            end else if (w_pop) begin
                r_ovld <= 1'b0;
            end
            if (w_commit && !(w_pop && r_dout_last))      r_pkt_cnt <= r_pkt_cnt + PW'(1);
            else if (!w_commit && (w_pop && r_dout_last)) r_pkt_cnt <= r_pkt_cnt - PW'(1);
            r_aful <= ({1'b0, w_used} + {1'b0, io_bus.i_aful_th}) >= DPTH_X;
            r_amty <= w_used <= io_bus.i_amty_th;
            r_ovfl <= w_ovfl_evt;
            r_unfl <= io_bus.i_rd & ~r_ovld;
        end
    end

    assign io_bus.o_dout      = r_dout;
    assign io_bus.o_dout_last = r_dout_last;
    assign io_bus.o_empty     = ~r_ovld;
    assign io_bus.o_full      = w_full;
    assign io_bus.o_aful      = r_aful;
    assign io_bus.o_amty      = r_amty;
    assign io_bus.o_ovfl_int  = r_ovfl;
    assign io_bus.o_unfl_int  = r_unfl;
    assign io_bus.o_used_cnt  = w_used;
    assign io_bus.o_pkt_cnt   = r_pkt_cnt;
endmodule

// File: tb/tb_cmip_sync_pkt_fifo.sv
// Bench for cmip_sync_pkt_fifo: vector table, directed corner sequences, random vs queue model.
`timescale 1ns/1ps
module tb_cmip_sync_pkt_fifo;
    localparam int unsigned DPTH = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmip_sync_pkt_fifo_if #(.DATA_WDTH(DW), .ADDR_WDTH(AW)) bus ();

    cmip_sync_pkt_fifo #(.DPTH(DPTH), .DATA_WDTH(DW), .ADDR_WDTH(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: open packet beats, committed backlog, visible head beat.
    logic [DW:0] m_pend[$];
    logic [DW:0] m_comm[$];
    logic [DW:0] m_hd;
    bit          m_hv, m_ovfl, m_unfl, m_aful, m_amty, m_disc;
    int          m_pkt;

    function automatic int m_used();
        return m_pend.size() + m_comm.size() + (m_hv ? 1 : 0);
    endfunction

    task automatic m_reset();
        m_pend.delete(); m_comm.delete();
        m_hd = '0; m_hv = 0; m_ovfl = 0; m_unfl = 0; m_aful = 0; m_amty = 1; m_disc = 0;
        m_pkt = 0;
    endtask

    task automatic m_step();
        int used0 = m_used();
        bit full0 = (m_pend.size() + m_comm.size()) == DPTH;
        bit pop   = bus.i_rd && m_hv;
        bit popl  = pop && m_hd[DW];
        bit ovf   = bus.i_wr && full0 && !bus.i_wr_drop && !m_disc;
        bit acc   = bus.i_wr && !full0 && !bus.i_wr_drop && !m_disc;
        m_ovfl = ovf;
        m_unfl = bus.i_rd && !m_hv;
        m_aful = (used0 + int'(bus.i_aful_th)) >= DPTH;
        m_amty = used0 <= int'(bus.i_amty_th);
        if (m_comm.size() > 0 && (!m_hv || pop)) begin
            m_hd = m_comm.pop_front();
            m_hv = 1;
        end else if (pop) begin
            m_hv = 0;
        end
`ifdef CMIP_PKT_FIFO_AUTO_DROP_EN
        if (m_disc) begin
            if ((bus.i_wr && bus.i_wr_last) || bus.i_wr_drop) m_disc = 0;
        end else if (ovf) begin
            m_pend.delete();
            m_disc = !bus.i_wr_last;
        end
`endif
        if (bus.i_wr_drop) begin
            m_pend.delete();
        end else if (acc) begin
            m_pend.push_back({bus.i_wr_last, bus.i_din});
            if (bus.i_wr_last) begin
                foreach (m_pend[i]) m_comm.push_back(m_pend[i]);
                m_pend.delete();
                m_pkt++;
            end
        end
        if (popl) m_pkt--;
    endtask

    task automatic m_cmp();
        chk("model empty", bus.o_empty, !m_hv);
        chk("model full", bus.o_full, (m_pend.size() + m_comm.size()) == DPTH);
        chk("model aful", bus.o_aful, m_aful);
        chk("model amty", bus.o_amty, m_amty);
        chk("model ovfl", bus.o_ovfl_int, m_ovfl);
        chk("model unfl", bus.o_unfl_int, m_unfl);
        chk("model used", bus.o_used_cnt, 64'(m_used()));
        chk("model pkt", bus.o_pkt_cnt, 64'(m_pkt));
        if (m_hv) chk("model head", {bus.o_dout_last, bus.o_dout}, m_hd);
    endtask

    task automatic step(input bit wr, input bit last, input bit drop, input bit rd,
                        input logic [DW-1:0] din);
        bus.i_wr = wr; bus.i_wr_last = last; bus.i_wr_drop = drop; bus.i_rd = rd;
        bus.i_din = din;
        @(posedge clk);
        m_step();
        #1;
        m_cmp();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " empty"}, bus.o_empty, 1'b1);
        chk({tag, " amty"}, bus.o_amty, 1'b1);
        chk({tag, " full"}, bus.o_full, 1'b0);
        chk({tag, " aful"}, bus.o_aful, 1'b0);
        chk({tag, " ovfl"}, bus.o_ovfl_int, 1'b0);
        chk({tag, " unfl"}, bus.o_unfl_int, 1'b0);
        chk({tag, " last"}, bus.o_dout_last, 1'b0);
        chk({tag, " dout"}, bus.o_dout, '0);
        chk({tag, " used"}, bus.o_used_cnt, '0);
        chk({tag, " pkt"}, bus.o_pkt_cnt, '0);
    endtask

    task automatic do_reset();
        bus.i_wr = 0; bus.i_wr_last = 0; bus.i_wr_drop = 0; bus.i_rd = 0; bus.i_din = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        bit          wr, last, drop, rd;
        logic [31:0] din;
        bit          e_empty;
        int          e_used, e_pkt;
        logic [31:0] e_dout;
        bit          e_last;
    } vec_t;

    function automatic vec_t mk(input bit wr, input bit last, input bit drop, input bit rd,
                                input logic [31:0] din, input bit e_empty, input int e_used,
                                input int e_pkt, input logic [31:0] e_dout, input bit e_last);
        vec_t v;
        v.wr = wr; v.last = last; v.drop = drop; v.rd = rd; v.din = din;
        v.e_empty = e_empty; v.e_used = e_used; v.e_pkt = e_pkt; v.e_dout = e_dout;
        v.e_last = e_last;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[18];
        tbl[0]  = mk(1, 0, 0, 0, 32'hA000_0000, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 32'hA000_0001, 1, 2, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 32'hA000_0002, 1, 3, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,         0, 3, 1, 32'hA000_0000, 0);
        tbl[4]  = mk(0, 0, 0, 1, 32'h0,         0, 2, 1, 32'hA000_0001, 0);
        tbl[5]  = mk(0, 0, 0, 1, 32'h0,         0, 1, 1, 32'hA000_0002, 1);
        tbl[6]  = mk(0, 0, 0, 1, 32'h0,         1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 32'hB000_0000, 1, 1, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 32'hB000_0001, 1, 2, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,         1, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 32'hC000_0000, 1, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,         0, 1, 1, 32'hC000_0000, 1);
        tbl[12] = mk(0, 0, 0, 1, 32'h0,         1, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 32'hD000_0000, 1, 1, 0, 0, 0);
        tbl[14] = mk(1, 0, 1, 0, 32'hD000_0001, 1, 0, 0, 0, 0);
        tbl[15] = mk(1, 1, 0, 0, 32'hE000_0000, 1, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 32'h0,         0, 1, 1, 32'hE000_0000, 1);
        tbl[17] = mk(0, 0, 0, 1, 32'h0,         1, 0, 0, 0, 0);

        bus.i_aful_th = 5'd4;
        bus.i_amty_th = 5'd2;
        bus.i_wr = 0; bus.i_wr_last = 0; bus.i_wr_drop = 0; bus.i_rd = 0; bus.i_din = '0;
        m_reset();
        do_reset();

        // Packet write/read, drop and coincident-drop vectors
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].wr, tbl[i].last, tbl[i].drop, tbl[i].rd, tbl[i].din);
            chk($sformatf("vec%0d empty", i), bus.o_empty, tbl[i].e_empty);
            chk($sformatf("vec%0d used", i), bus.o_used_cnt, 64'(tbl[i].e_used));
            chk($sformatf("vec%0d pkt", i), bus.o_pkt_cnt, 64'(tbl[i].e_pkt));
            if (!tbl[i].e_empty) begin
                chk($sformatf("vec%0d dout", i), bus.o_dout, tbl[i].e_dout);
                chk($sformatf("vec%0d last", i), bus.o_dout_last, tbl[i].e_last);
            end
        end

        // Fill with an open packet, then overflow
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 32'h100 + i);
        chk("fill full", bus.o_full, 1'b1);
        chk("fill empty", bus.o_empty, 1'b1);
        chk("fill used", bus.o_used_cnt, 16);
        step(1, 0, 0, 0, 32'h1FF);
        chk("ovfl pulse", bus.o_ovfl_int, 1'b1);
`ifdef CMIP_PKT_FIFO_AUTO_DROP_EN
        chk("autodrop used", bus.o_used_cnt, 0);
        step(0, 0, 0, 0, 0);
        chk("ovfl once", bus.o_ovfl_int, 1'b0);
        step(1, 0, 0, 0, 32'h200);
        chk("discard used", bus.o_used_cnt, 0);
        step(1, 1, 0, 0, 32'h201);
        chk("discard end used", bus.o_used_cnt, 0);
        chk("discard end pkt", bus.o_pkt_cnt, 0);
`else
        chk("ovfl hold used", bus.o_used_cnt, 16);
        step(0, 0, 0, 0, 0);
        chk("ovfl once", bus.o_ovfl_int, 1'b0);
        step(0, 0, 1, 0, 0);
        chk("drop used", bus.o_used_cnt, 0);
        chk("drop full", bus.o_full, 1'b0);
`endif
        step(1, 1, 0, 0, 32'hF0);
        chk("single used", bus.o_used_cnt, 1);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, i == 15, 0, 0, 32'h300 + i);
        chk("full+head used", bus.o_used_cnt, 17);
        chk("full+head full", bus.o_full, 1'b1);
        step(1, 1, 0, 1, 32'h3FF);
        chk("wr+pop ovfl", bus.o_ovfl_int, 1'b1);
        chk("wr+pop full", bus.o_full, 1'b0);
        chk("wr+pop used", bus.o_used_cnt, 16);
        chk("wr+pop dout", bus.o_dout, 32'h300);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
        chk("drain empty", bus.o_empty, 1'b1);
        chk("drain pkt", bus.o_pkt_cnt, 0);

        // Almost-full / almost-empty thresholds
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1, i == 12, 0, 0, 32'h400 + i);
            chk($sformatf("aful lag%0d", i), bus.o_aful, 1'b0);
        end
        step(0, 0, 0, 0, 0);
        chk("aful rise", bus.o_aful, 1'b1);
        chk("aful used", bus.o_used_cnt, 12);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 1, 0);
            chk($sformatf("amty lag%0d", k), bus.o_amty, 1'b0);
        end
        chk("amty used", bus.o_used_cnt, 2);
        step(0, 0, 0, 0, 0);
        chk("amty rise", bus.o_amty, 1'b1);

        // Streaming single-beat packets
        do_reset();
        step(1, 1, 0, 0, 32'h500);
        step(1, 1, 0, 0, 32'h501);
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 1, 32'h502 + k);
            chk($sformatf("stream%0d empty", k), bus.o_empty, 1'b0);
            chk($sformatf("stream%0d pkt", k), bus.o_pkt_cnt, 2);
            chk($sformatf("stream%0d dout", k), bus.o_dout, 32'h501 + k);
            chk($sformatf("stream%0d ints", k), {bus.o_ovfl_int, bus.o_unfl_int}, 2'b00);
        end

        // Asynchronous reset mid-packet
        do_reset();
        bus.i_aful_th = 5'd15;
        step(1, 1, 0, 0, 32'h600);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h610 + i);
        chk("pre-rst used", bus.o_used_cnt, 5);
        chk("pre-rst aful", bus.o_aful, 1'b1);
        chk("pre-rst last", bus.o_dout_last, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        bus.i_aful_th = 5'd4;
        step(1, 1, 0, 0, 32'h700);
        chk("post-rst pkt", bus.o_pkt_cnt, 1);
        step(0, 0, 0, 0, 0);
        chk("post-rst dout", bus.o_dout, 32'h700);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 256 == 0) begin
                bus.i_aful_th = 5'($urandom_range(0, 17));
                bus.i_amty_th = 5'($urandom_range(0, 17));
            end
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 50, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
